cdc_hs_tx: RTL and testbench

Source-domain transmitter for the 4-phase req/ack clock-domain-crossing handshake. It accepts a data word via valid/ready, launches it across the boundary with tx_data and tx_req, and waits for the destination's acknowledge. The acknowledge is synchronised locally through a sync_cell instance. The destination-side receiver samples tx_data once its synchronised tx_req is high.

---
 rtl/cdc_hs_pkg.sv | 14 +
 rtl/cdc_hs_tx_sync_cell.sv | 26 ++
 rtl/cdc_hs_tx.sv | 124 ++++++++++++
 tb/tb_cdc_hs_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared constants for the 4-phase req/ack CDC handshake.
// Used by the source transmitter and the matching destination receiver.
package cdc_hs_pkg;

    // Both sides of the crossing synchronise with the same depth.
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

endpackage

// File: rtl/cdc_hs_tx_sync_cell.sv
// Multi-flop level synchroniser for a single asynchronous bit.
// All flops clear to 0 on reset.
module sync_cell
    import cdc_hs_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic out_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_i};
        end
    end

    assign out_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-side transmitter of the 4-phase req/ack CDC handshake.
// Accepts a word via valid/ready and holds it on tx_data until ack drops.
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              tx_req,
    output logic [DATA_W-1:0] tx_data,
    input  logic              rx_ack,
    output logic              xfer_done,
    output logic              busy,
    output logic              err_timeout
);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              ack_s;

    sync_cell #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (rx_ack),
        .out_o (ack_s)
    );

    // A stale ack from a previous handshake blocks new accepts.
    assign src_ready = (state_q == ST_IDLE) && !ack_s;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (src_valid && src_ready) begin
                    data_d  = src_data;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign tx_req    = req_q;
    assign tx_data   = data_q;
    assign xfer_done = done_q;

    if (TIMEOUT > 0) begin : g_tmo
        localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             err_q, err_d;

        // Flag only; the handshake is never aborted.
        always_comb begin
            cnt_d = cnt_q;
            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (busy && (cnt_q != TMO)) begin
                cnt_d = cnt_q + 1'b1;
            end
            err_d = err_q | (cnt_d == TMO);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                err_q <= err_d;
            end
        end

        assign err_timeout = err_q;
    end else begin : g_no_tmo
        assign err_timeout = 1'b0;
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed self-checking bench for cdc_hs_tx (DATA_W=8, TIMEOUT=16).
// The bench plays the destination receiver by driving rx_ack by hand.
module tb_cdc_hs_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       rx_ack = 1'b0;
    logic       xfer_done;
    logic       busy;
    logic       err_timeout;

    int checks = 0;
    int failures = 0;

    logic       mon_en = 1'b0;
    int         done_cnt = 0;
    logic [7:0] seen_q[$];
    logic       busy_prev = 1'b0;
    logic       req_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    cdc_hs_tx #(
        .DATA_W  (8),
        .TIMEOUT (16),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .rx_ack      (rx_ack),
        .xfer_done   (xfer_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Monitor: counts done pulses, logs launched words, checks hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (xfer_done === 1'b1) done_cnt++;
            if (tx_req === 1'b1 && req_prev !== 1'b1) seen_q.push_back(tx_data);
            if (busy === 1'b1 && busy_prev === 1'b1) begin
                checks++;
                if (tx_data !== data_prev) begin
                    failures++;
                    $display("FAIL hold: tx_data=%h was %h while busy",
                             tx_data, data_prev);
                end
            end
        end
        busy_prev = busy;
        req_prev  = tx_req;
        data_prev = tx_data;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input logic lvl);
        int k = 0;
        while (tx_req !== lvl && k < 60) begin
            step();
            k++;
        end
        checks++;
        if (tx_req !== lvl) begin
            failures++;
            $display("FAIL wait_req: tx_req=%b want %b", tx_req, lvl);
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while (xfer_done !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        checks++;
        if (xfer_done !== 1'b1) begin
            failures++;
            $display("FAIL wait_done: xfer_done=%b want 1", xfer_done);
        end
    endtask

    task automatic finish_hs();
        step(2);
        rx_ack = 1'b1;
        wait_req(1'b0);
        rx_ack = 1'b0;
        wait_done();
        step();
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (tx_req !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 ||
            xfer_done !== 1'b0 || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL %s: req=%b data=%h busy=%b done=%b err=%b want 0s",
                     tag, tx_req, tx_data, busy, xfer_done, err_timeout);
        end
    endtask

    task automatic test_reset();
        src_valid = 1'b1;
        src_data  = 8'h99;
        #2;
        check_reset_vals("reset_init");
        step(2);
        src_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (src_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: src_ready=%b want 1", src_ready);
        end
        step(2);
    endtask

    task automatic test_single();
        src_data  = 8'hA5;
        src_valid = 1'b1;
        step();
        src_valid = 1'b0;
        checks++;
        if (tx_req !== 1'b1 || tx_data !== 8'hA5 || src_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_accept: req=%b data=%h rdy=%b want 1 a5 0",
                     tx_req, tx_data, src_ready);
        end
        step(4);
        rx_ack = 1'b1;
        step(2);
        checks++;
        if (tx_req !== 1'b1) begin
            failures++;
            $display("FAIL single_req_hold: tx_req=%b want 1", tx_req);
        end
        step();
        checks++;
        if (tx_req !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_req_fall: req=%b busy=%b want 0 1",
                     tx_req, busy);
        end
        rx_ack = 1'b0;
        step(2);
        checks++;
        if (xfer_done !== 1'b0 || src_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_early_done: done=%b rdy=%b want 0 0",
                     xfer_done, src_ready);
        end
        step();
        checks++;
        if (xfer_done !== 1'b1 || src_ready !== 1'b1 || tx_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_done: done=%b rdy=%b data=%h want 1 1 a5",
                     xfer_done, src_ready, tx_data);
        end
        step();
        checks++;
        if (xfer_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_pulse: done=%b busy=%b want 0 0",
                     xfer_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        seen_q.delete();
        done_cnt = 0;
        mon_en = 1'b1;
        src_data  = 8'h01;
        src_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req(1'b1);
            if (i < 2) src_data = 8'(i + 2);
            else src_valid = 1'b0;
            step(2);
            rx_ack = 1'b1;
            wait_req(1'b0);
            rx_ack = 1'b0;
            wait_done();
        end
        step(4);
        mon_en = 1'b0;
        checks++;
        if (done_cnt !== 3) begin
            failures++;
            $display("FAIL b2b_done_cnt: got %0d want 3", done_cnt);
        end
        checks++;
        if (seen_q.size() != 3 || seen_q[0] !== 8'h01 ||
            seen_q[1] !== 8'h02 || seen_q[2] !== 8'h03) begin
            failures++;
            $display("FAIL b2b_order: got %p want 01 02 03", seen_q);
        end
    endtask

    task automatic test_stale_ack();
        int bad = 0;
        rx_ack = 1'b1;
        step(2);
        src_data  = 8'h77;
        src_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (src_ready !== 1'b0 || tx_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stale_block: %0d cycles with ready/req high", bad);
        end
        rx_ack = 1'b0;
        step(2);
        checks++;
        if (tx_req !== 1'b0 || src_ready !== 1'b1) begin
            failures++;
            $display("FAIL stale_release: req=%b rdy=%b want 0 1",
                     tx_req, src_ready);
        end
        step();
        src_valid = 1'b0;
        checks++;
        if (tx_req !== 1'b1 || tx_data !== 8'h77) begin
            failures++;
            $display("FAIL stale_accept: req=%b data=%h want 1 77",
                     tx_req, tx_data);
        end
        finish_hs();
    endtask

    task automatic test_timeout_busy_ignore();
        done_cnt = 0;
        mon_en = 1'b1;
        src_data  = 8'h3C;
        src_valid = 1'b1;
        step();
        src_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (i == 5) begin
                src_data  = 8'hFF;
                src_valid = 1'b1;
            end
            if (i == 7) src_valid = 1'b0;
            step();
        end
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early: err=%b want 0 at 15 cycles", err_timeout);
        end
        step();
        checks++;
        if (err_timeout !== 1'b1 || tx_req !== 1'b1 || tx_data !== 8'h3C) begin
            failures++;
            $display("FAIL tmo_set: err=%b req=%b data=%h want 1 1 3c",
                     err_timeout, tx_req, tx_data);
        end
        step(5);
        finish_hs();
        step(4);
        mon_en = 1'b0;
        checks++;
        if (err_timeout !== 1'b1 || tx_data !== 8'h3C || tx_req !== 1'b0) begin
            failures++;
            $display("FAIL tmo_after: err=%b data=%h req=%b want 1 3c 0",
                     err_timeout, tx_data, tx_req);
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL busy_ignore: done pulses=%0d want 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        src_data  = 8'h5A;
        src_valid = 1'b1;
        step();
        checks++;
        if (tx_req !== 1'b1 || tx_data !== 8'h5A) begin
            failures++;
            $display("FAIL mid_accept: req=%b data=%h want 1 5a",
                     tx_req, tx_data);
        end
        step(2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        step(2);
        src_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (src_ready !== 1'b1 || tx_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_release: rdy=%b req=%b want 1 0",
                     src_ready, tx_req);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stale_ack();
        test_timeout_busy_ignore();
        test_reset_mid();
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
